rf_writeback: RTL

- Write-back stage feeding the register file's write port: RF_Addr_Write, RF_Bus_Write, RF_Load_Write, RF_Flags_Write, RF_Load_Flags.
- Merges single-cycle ALU results with load-data returns. Loads are buffered in a small queue, and ALU results have fixed priority.
- Maintains a pending-load scoreboard so decode can stall on registers with outstanding loads.
- Guarantees at most one register write per cycle.

---
 rtl/rf_writeback_pkg.sv | 17 +
 rtl/rf_wb_ldq.sv | 86 ++++++++
 rtl/rf_writeback.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rf_writeback_pkg.sv
package rf_writeback_pkg;

    localparam int RF_ADDRLEN  = 4;
    localparam int RF_DBUSLEN  = 32;
    localparam int RF_FLAGSLEN = 32;

    localparam logic [RF_FLAGSLEN-1:0] RF_MODE_USER = 'h10;

    localparam int RF_LDQ_DEPTH = 2;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2
    } wb_src_e;

endpackage

// File: rtl/rf_wb_ldq.sv
// Load-return FIFO of {valid, addr, data}; ALU writes can kill matching entries,
// which then still occupy their slot and pop without writing.
module rf_wb_ldq
    import rf_writeback_pkg::*;
#(
    parameter int ADDRLEN = RF_ADDRLEN,
    parameter int DBUSLEN = RF_DBUSLEN,
    parameter int DEPTH   = RF_LDQ_DEPTH,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic               sysclk,
    input  logic               nreset,
    input  logic               push,
    input  logic [ADDRLEN-1:0] push_addr,
    input  logic [DBUSLEN-1:0] push_data,
    input  logic               pop,
    input  logic               kill,
    input  logic [ADDRLEN-1:0] kill_addr,
    output logic [CW-1:0]      count,
    output logic               head_valid,
    output logic [ADDRLEN-1:0] head_addr,
    output logic [DBUSLEN-1:0] head_data,
    output logic               kill_hit
);

    logic [DEPTH-1:0]   ent_valid;
    logic [DEPTH-1:0]   valid_next;
    logic [DEPTH-1:0]   kill_match;
    logic [ADDRLEN-1:0] ent_addr [DEPTH];
    logic [DBUSLEN-1:0] ent_data [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;

    always_comb begin
        kill_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_match[i] = ent_valid[i] && (ent_addr[i] == kill_addr);
        end
    end

    assign kill_hit   = kill && (|kill_match);
    assign head_valid = ent_valid[rd_ptr];
    assign head_addr  = ent_addr[rd_ptr];
    assign head_data  = ent_data[rd_ptr];

    // Free slots always hold valid=0, so a kill only ever touches live entries.
    always_comb begin
        valid_next = ent_valid;
        if (kill) begin
            valid_next = valid_next & ~kill_match;
        end
        if (pop) begin
            valid_next[rd_ptr] = 1'b0;
        end
        if (push) begin
            valid_next[wr_ptr] = 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge nreset) begin
        if (!nreset) begin
            ent_valid <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            ent_valid <= valid_next;
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) begin
            ent_addr[wr_ptr] <= push_addr;
            ent_data[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// Register-file write-back: ALU results take the write port first, queued load
// returns fill idle edges, and a scoreboard tracks registers with loads in flight.
module rf_writeback
    import rf_writeback_pkg::*;
#(
    parameter int ADDRLEN   = RF_ADDRLEN,
    parameter int DBUSLEN   = RF_DBUSLEN,
    parameter int FLAGSLEN  = RF_FLAGSLEN,
    parameter int LDQ_DEPTH = RF_LDQ_DEPTH,
    localparam int NREG     = 1 << ADDRLEN,
    localparam int CW       = $clog2(LDQ_DEPTH) + 1
) (
    input  logic                sysclk,
    input  logic                nreset,
    input  logic                alu_valid,
    input  logic [ADDRLEN-1:0]  alu_addr,
    input  logic [DBUSLEN-1:0]  alu_data,
    input  logic [FLAGSLEN-1:0] alu_flags,
    input  logic                alu_load_flags,
    input  logic                ld_valid,
    input  logic [ADDRLEN-1:0]  ld_addr,
    input  logic [DBUSLEN-1:0]  ld_data,
    output logic                ld_ready,
    input  logic                issue_ld,
    input  logic [ADDRLEN-1:0]  issue_addr,
    output logic [NREG-1:0]     pending_mask,
    output logic [ADDRLEN-1:0]  RF_Addr_Write,
    output logic [DBUSLEN-1:0]  RF_Bus_Write,
    output logic                RF_Load_Write,
    output logic [FLAGSLEN-1:0] RF_Flags_Write,
    output logic                RF_Load_Flags
);

    logic               rdy_en;
    logic               q_push;
    logic               q_pop;
    logic [CW-1:0]      q_count;
    logic               q_head_valid;
    logic [ADDRLEN-1:0] q_head_addr;
    logic [DBUSLEN-1:0] q_head_data;
    logic               q_kill_hit;
    wb_src_e            wb_src;
    logic [NREG-1:0]    pend_set;
    logic [NREG-1:0]    pend_clr;
    logic [NREG-1:0]    pend_next;

    // rdy_en keeps ld_ready low through reset and the cycle it is released.
    assign ld_ready = rdy_en && (q_count < CW'(LDQ_DEPTH));
    assign q_push   = ld_valid && ld_ready;
    assign q_pop    = !alu_valid && (q_count != '0);

    rf_wb_ldq #(
        .ADDRLEN (ADDRLEN),
        .DBUSLEN (DBUSLEN),
        .DEPTH   (LDQ_DEPTH)
    ) u_ldq (
        .sysclk     (sysclk),
        .nreset     (nreset),
        .push       (q_push),
        .push_addr  (ld_addr),
        .push_data  (ld_data),
        .pop        (q_pop),
        .kill       (alu_valid),
        .kill_addr  (alu_addr),
        .count      (q_count),
        .head_valid (q_head_valid),
        .head_addr  (q_head_addr),
        .head_data  (q_head_data),
        .kill_hit   (q_kill_hit)
    );

    always_comb begin
        wb_src = WB_IDLE;
        if (alu_valid) begin
            wb_src = WB_ALU;
        end else if (q_pop && q_head_valid) begin
            wb_src = WB_LOAD;
        end
    end

    // A newly issued load outlives any clear aimed at the same register.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (issue_ld) begin
            pend_set[issue_addr] = 1'b1;
        end
        if (wb_src == WB_LOAD) begin
            pend_clr[q_head_addr] = 1'b1;
        end
        if (q_kill_hit) begin
            pend_clr[alu_addr] = 1'b1;
        end
        pend_next = (pending_mask & ~pend_clr) | pend_set;
    end

    always_ff @(posedge sysclk or negedge nreset) begin
        if (!nreset) begin
            rdy_en       <= 1'b0;
            pending_mask <= '0;
        end else begin
            rdy_en       <= 1'b1;
            pending_mask <= pend_next;
        end
    end

    always_ff @(posedge sysclk or negedge nreset) begin
        if (!nreset) begin
            RF_Load_Write  <= 1'b0;
            RF_Addr_Write  <= '0;
            RF_Bus_Write   <= '0;
            RF_Load_Flags  <= 1'b0;
            RF_Flags_Write <= '0;
        end else begin
            case (wb_src)
                WB_ALU: begin
                    RF_Load_Write  <= 1'b1;
                    RF_Addr_Write  <= alu_addr;
                    RF_Bus_Write   <= alu_data;
                    RF_Load_Flags  <= alu_load_flags;
                    RF_Flags_Write <= alu_flags;
                end
                WB_LOAD: begin
                    RF_Load_Write  <= 1'b1;
                    RF_Addr_Write  <= q_head_addr;
                    RF_Bus_Write   <= q_head_data;
                    RF_Load_Flags  <= 1'b0;
                    RF_Flags_Write <= '0;
                end
                default: begin
                    RF_Load_Write  <= 1'b0;
                    RF_Addr_Write  <= '0;
                    RF_Bus_Write   <= '0;
                    RF_Load_Flags  <= 1'b0;
                    RF_Flags_Write <= '0;
                end
            endcase
        end
    end

endmodule
